// File: rtl/nios_pio_pkg.sv
// Shared register map and pulse-field layout for the Nios PIO blocks.
package nios_pio_pkg;

  typedef enum logic [1:0] {
    PIO_DATA  = 2'd0,
    PIO_SET   = 2'd1,
    PIO_CLR   = 2'd2,
    PIO_PULSE = 2'd3
  } pio_addr_e;

  localparam int unsigned PULSE_CNT_W    = 16;
  localparam int unsigned PULSE_CNT_LSB  = 16;
  localparam int unsigned PULSE_MASK_LSB = 0;

endpackage

// File: rtl/nios_pio_out_pulse_timer.sv
// One-shot pulse timer: a loadable down-counter plus the bit mask it inverts.
module nios_pio_pulse_timer
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [PULSE_CNT_W-1:0] count,
  input  logic [WIDTH-1:0]       mask,
  output logic                   active,
  output logic [PULSE_CNT_W-1:0] remaining,
  output logic [WIDTH-1:0]       mask_q,
  output logic [WIDTH-1:0]       mask_next
);

  logic [PULSE_CNT_W-1:0] cnt_q;
  logic [PULSE_CNT_W-1:0] cnt_next;

  // A load always wins over the decrement, so a reload on the last pulse
  // cycle continues seamlessly and a zero count cancels immediately.
  always_comb begin
    cnt_next  = cnt_q;
    mask_next = mask_q;
    if (load) begin
      cnt_next  = count;
      mask_next = mask;
    end else if (cnt_q != '0) begin
      cnt_next = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_next;
      mask_q <= mask_next;
    end
  end

  // Pulse state for the coming cycle; feeds the registered output directly.
  assign active    = (cnt_next != '0);
  assign remaining = cnt_q;

endmodule

// File: rtl/nios_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a timed bit-inversion pulse.
module nios_pio_out_pulse
  import nios_pio_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]       data_q;
  logic [WIDTH-1:0]       data_next;
  logic                   wr_en;
  logic                   pulse_load;
  logic                   pulse_active;
  logic [PULSE_CNT_W-1:0] pulse_remaining;
  logic [WIDTH-1:0]       pulse_mask;
  logic [WIDTH-1:0]       pulse_mask_next;
  logic [WIDTH-1:0]       wr_bits;
  logic [31:0]            rd_mux;
  logic [15:0]            mask_ext;

  assign wr_en      = chipselect && write;
  assign wr_bits    = writedata[PULSE_MASK_LSB +: WIDTH];
  assign pulse_load = wr_en && (pio_addr_e'(address) == PIO_PULSE);

  nios_pio_pulse_timer #(
    .WIDTH (WIDTH)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (pulse_load),
    .count     (writedata[PULSE_CNT_LSB +: PULSE_CNT_W]),
    .mask      (wr_bits),
    .active    (pulse_active),
    .remaining (pulse_remaining),
    .mask_q    (pulse_mask),
    .mask_next (pulse_mask_next)
  );

  always_comb begin
    data_next = data_q;
    if (wr_en) begin
      case (pio_addr_e'(address))
        PIO_DATA: data_next = wr_bits;
        PIO_SET:  data_next = data_q | wr_bits;
        PIO_CLR:  data_next = data_q & ~wr_bits;
        default:  data_next = data_q;
      endcase
    end
  end

  // Readback uses pre-write register values.
  always_comb begin
    mask_ext             = '0;
    mask_ext[WIDTH-1:0]  = pulse_mask;
    rd_mux               = '0;
    if (pio_addr_e'(address) == PIO_PULSE) begin
      rd_mux = {pulse_remaining, mask_ext};
    end else begin
      rd_mux[WIDTH-1:0] = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      out_port <= RESET_VALUE;
      readdata <= '0;
    end else begin
      data_q   <= data_next;
      out_port <= data_next ^ (pulse_active ? pulse_mask_next : '0);
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_nios_pio_out_pulse.sv
// Scoreboard bench for nios_pio_out_pulse against an absolute-time pulse model.
module tb_nios_pio_out_pulse;

  localparam int unsigned W  = 8;
  localparam logic [W-1:0] RV = 8'h5A;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] out_port;

  nios_pio_out_pulse #(
    .WIDTH       (W),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic [31:0]  rd;
    int           edge_no;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: data and mask plus the absolute edge at which the pulse ends.
  logic [W-1:0] m_data = RV;
  logic [W-1:0] m_mask = '0;
  int           m_end  = 0;
  int           e      = 0;

  task automatic step(input logic r, input logic cs, input logic wr,
                      input logic [1:0] a, input logic [31:0] wd);
    exp_t x;
    int   rem;
    @(negedge clk);
    reset = r; chipselect = cs; write = wr; address = a; writedata = wd;
    e++;
    x.edge_no = e;
    if (r) begin
      m_data = RV; m_mask = '0; m_end = e;
      x.rd  = '0;
      x.out = RV;
    end else begin
      rem = m_end - (e - 1);
      if (rem < 0) rem = 0;
      if (a == 2'd3) x.rd = {rem[15:0], 8'h00, m_mask};
      else           x.rd = {24'h0, m_data};
      if (cs && wr) begin
        case (a)
          2'd0: m_data = wd[W-1:0];
          2'd1: m_data = m_data | wd[W-1:0];
          2'd2: m_data = m_data & ~wd[W-1:0];
          default: begin
            m_mask = wd[W-1:0];
            m_end  = e + int'(wd[31:16]);
          end
        endcase
      end
      x.out = m_data ^ ((e < m_end) ? m_mask : '0);
    end
    q.push_back(x);
  endtask

  task automatic idle(input logic [1:0] a);
    step(1'b0, 1'b0, 1'b0, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    step(1'b0, 1'b1, 1'b1, a, wd);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_checks++;
      if (out_port !== x.out) begin
        n_fail++;
        $display("FAIL out_port edge %0d: got %h expected %h", x.edge_no, out_port, x.out);
      end
      n_checks++;
      if (readdata !== x.rd) begin
        n_fail++;
        $display("FAIL readdata edge %0d: got %h expected %h", x.edge_no, readdata, x.rd);
      end
    end
  end

  initial begin
    logic [31:0] wd;
    logic [1:0]  a;
    // reset value and first read
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
    idle(2'd0); idle(2'd0);
    // set / clear sequence
    wr(2'd0, 32'h0000_000F); wr(2'd1, 32'h0000_0030); wr(2'd2, 32'h0000_0003);
    idle(2'd0);
    // basic pulse with mid-pulse readback
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h0003_0081);
    repeat (5) idle(2'd3);
    // restart
    wr(2'd3, 32'h0005_00F0); idle(2'd3); idle(2'd3);
    wr(2'd3, 32'h0002_0001);
    repeat (4) idle(2'd3);
    // cancel
    wr(2'd3, 32'h0004_0018); idle(2'd3);
    wr(2'd3, 32'h0000_0018);
    repeat (2) idle(2'd3);
    // reload on the cnt==1 cycle
    wr(2'd3, 32'h0002_0042); idle(2'd3);
    wr(2'd3, 32'h0003_0024);
    repeat (4) idle(2'd3);
    // data write during pulse, then reset mid-pulse
    wr(2'd3, 32'h0006_00C3); wr(2'd0, 32'hFFFF_FF11); idle(2'd3);
    step(1'b1, 1'b0, 1'b0, 2'd3, 32'h0);
    idle(2'd3); idle(2'd0);
    // chipselect low write ignored
    step(1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_00EE);
    step(1'b0, 1'b0, 1'b1, 2'd3, 32'h0009_00EE);
    idle(2'd3);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      wd = $urandom;
      a  = 2'($urandom_range(0, 3));
      if (a == 2'd3 && $urandom_range(0, 7) != 0)
        wd[31:16] = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 99) == 0)
        step(1'b1, 1'($urandom), 1'($urandom), a, wd);
      else
        step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), a, wd);
    end
    idle(2'd0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_pio_out_pulse.md
# nios_pio_out_pulse

Avalon-MM slave output PIO for the Nios subsystem, the write-side counterpart of the system's read-only input PIOs. It drives a `WIDTH`-bit `out_port` from a software-written data register. It supports atomic bit set and clear, plus a hardware one-shot pulse that inverts selected bits for a programmed number of clock cycles. All registers read back with fixed one-cycle latency.

## Interface
- `WIDTH`, default 8: output port width, 1..16.
- `RESET_VALUE`, default 0: reset value of the data register, `WIDTH` bits.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `address`  in  2: register word select.
- `chipselect`  in  1: slave selected.
- `write`  in  1: write strobe; a write is valid only when `chipselect` is also high.
- `writedata`  in  32: write data.
- `readdata`  out  32: registered read data.
- `out_port`  out  `WIDTH`: registered output pins.

## Operation
- Register map. Writes act when `chipselect && write`.
  - Address 0, DATA: `data <= writedata[WIDTH-1:0]`.
  - Address 1, SET: `data <= data | writedata[WIDTH-1:0]`.
  - Address 2, CLEAR: `data <= data & ~writedata[WIDTH-1:0]`.
  - Address 3, PULSE: `mask <= writedata[WIDTH-1:0]`; `cnt <= writedata[31:16]`.
- Pulse state machine, tracked by `cnt`:
  - IDLE: `cnt == 0`.
  - PULSING: `cnt != 0`. Decrement by 1 each clock; return to IDLE when `cnt` reaches 0.
- PULSE write with count 0: cancels any active pulse and forces IDLE.
- PULSE write while PULSING: restarts with the new mask and count. No extra cycle is inserted.
- PULSE write on the cycle `cnt == 1`: the new write wins and the load replaces the decrement.
- DATA/SET/CLEAR writes during a pulse: take effect immediately. The pulse continues, so the output is the new data XOR mask.
- Output: `out_port <= data_next ^ (cnt_next != 0 ? mask_next : 0)`. `out_port` is a flop with no combinational path from bus inputs.
- Readback mux, with the result zero-extended:
  - Address 0: `data`.
  - Address 1: `data`.
  - Address 2: `data`.
  - Address 3: `{cnt, {16-WIDTH{0}}, mask}`, where `cnt` is the remaining count.
- Registers read back as their pre-write values when read and write occur in the same cycle.
- Write bits above `WIDTH` in the data field are ignored.

## Timing
- Reset values: `data = RESET_VALUE`, `mask = 0`, `cnt = 0`, `out_port = RESET_VALUE`, `readdata = 0`.
- Reset mid-pulse aborts the pulse on the same edge.
- Write latency: a write sampled at edge N is visible on `out_port` after edge N, i.e. during cycle N+1.
- Pulse length: a PULSE write with count C > 0 at edge N gives an inverted `out_port` during exactly cycles N+1 .. N+C. The output returns to `data` after edge N+C.
- Read latency: `readdata` is loaded every clock from the `address` mux, independent of `chipselect`. Data for the address at edge N is valid after edge N, so wait-states are fixed at 1.
- No `waitrequest`; the slave accepts a write every cycle.

## Structure
- Shared package `nios_pio_pkg`:
  - Register address constants `PIO_DATA = 0`, `PIO_SET = 1`, `PIO_CLR = 2`, `PIO_PULSE = 3`.
  - `PULSE_CNT_W = 16`.
  - Field positions `PULSE_CNT_LSB = 16` and `PULSE_MASK_LSB = 0`.
- Sub-module `nios_pio_pulse_timer` holds the load/decrement counter plus the mask register.
  - Inputs: load, count, mask.
  - Outputs: active, remaining count.
- The top level holds the data register, write decode, output flop and read mux.
- Target size is about 150 lines of RTL.

## Test plan
- Reset value: `RESET_VALUE = 8'h5A`, reset held 3 cycles then released → `out_port = 8'h5A`, `readdata = 0`; a read of address 0 returns `32'h5A`.
- Set/clear: write DATA `0x0F`, then SET `0x30`, then CLEAR `0x03` on consecutive cycles → `out_port` steps `0x0F`, `0x3F`, `0x3C`, one cycle after each write.
- Pulse: with DATA `0x00`, write PULSE `0x0003_0081` → `out_port = 0x81` for exactly 3 cycles, then `0x00`. A read of address 3 mid-pulse returns the decremented count, e.g. `0x0002_0081`.
- Restart and cancel:
  - PULSE count 5, then PULSE `0x0002_0001` at cycle 3 → inversion uses the new mask for 2 further cycles.
  - PULSE count 0 mid-pulse → output returns to `data` on the next cycle.
- Boundaries:
  - A new PULSE write on the cycle `cnt == 1` → no gap and no extra cycle.
  - `reset` asserted mid-pulse → `out_port = RESET_VALUE` and `cnt = 0` on the next cycle.
  - A write with `chipselect = 0` → no register change.
